// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if: valid/ready input and output streams of the Gray/binary converter.
// The master drives words in and accepts results; the slave is the converter.
interface gray_codec_pipe_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
  logic             out_adj_err;
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_adj_err
  );
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_adj_err
  );
endinterface

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined binary<->Gray converter with valid/ready flow control.
// Define GRAY_CODEC_ADJ_CHECK_EN to flag Gray inputs not one bit away from the previous one.
module gray_codec_pipe #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  gray_codec_pipe_if.slave bus
);
  logic [STAGES-1:0] vld, mode, err, adv;
  logic [WIDTH-1:0]  data [STAGES];
  logic [WIDTH-1:0]  conv;
  logic              conv_err;
  // Gray->binary bit i is the XOR of all Gray bits at or above i
  always_comb begin
    conv = bus.in_data ^ (bus.in_data >> 1);
    if (bus.in_mode)
      for (int i = 0; i < WIDTH; i++) conv[i] = ^(bus.in_data >> i);
  end
  // A stage may load when empty or when its word leaves this cycle
  always_comb begin
    adv[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
    for (int k = STAGES-2; k >= 0; k--) adv[k] = !vld[k] || adv[k+1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      mode <= '0;
      err  <= '0;
      for (int k = 0; k < STAGES; k++) data[k] <= '0;
    end else begin
      if (adv[0]) begin
        vld[0]  <= bus.in_valid;
        mode[0] <= bus.in_mode;
        err[0]  <= conv_err;
        data[0] <= conv;
      end
      for (int k = 1; k < STAGES; k++)
        if (adv[k]) begin
          vld[k]  <= vld[k-1];
          mode[k] <= mode[k-1];
          err[k]  <= err[k-1];
          data[k] <= data[k-1];
        end
    end
  end
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic [WIDTH-1:0] ref_word;
  logic             ref_valid;
  logic             accept;
  assign accept   = bus.in_valid && adv[0];
  assign conv_err = bus.in_mode && ref_valid && ($countones(bus.in_data ^ ref_word) != 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_word  <= '0;
      ref_valid <= 1'b0;
    end else if (accept && bus.in_mode) begin
      ref_word  <= bus.in_data;
      ref_valid <= 1'b1;
    end
  end
`else
  assign conv_err = 1'b0;
`endif
  assign bus.in_ready    = adv[0];
  assign bus.out_valid   = vld[STAGES-1];
  assign bus.out_mode    = mode[STAGES-1];
  assign bus.out_adj_err = err[STAGES-1];
  assign bus.out_data    = data[STAGES-1];
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: directed and random stimulus against an arithmetic reference model
// of the converter, with a FIFO scoreboard, stall-hold checks and adjacency-flag checks.
module tb_gray_codec_pipe;
  localparam int W = 5;
  localparam int S = 2;
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif
  typedef struct {
    logic         m;
    logic [W-1:0] d;
    logic         e;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  gray_codec_pipe_if #(.WIDTH(W)) bus ();
  gray_codec_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, acc_cnt = 0, xfer_cnt = 0;
  word_t q[$];
  word_t w, held;
  logic err_log[$];
  logic [W-1:0] ref_word, prev;
  logic ref_valid, hold, stream_on, have_prev;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: Gray->binary as the XOR of all right shifts of the code word
  function automatic word_t model(logic m, logic [W-1:0] d);
    word_t r;
    r.m = m;
    r.e = 1'b0;
    if (!m) r.d = d ^ (d >> 1);
    else begin
      r.d = '0;
      for (int s = 0; s < W; s++) r.d ^= d >> s;
      r.e = ADJ && ref_valid && ($countones(d ^ ref_word) != 1);
      ref_word  = d;
      ref_valid = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, held.d);
        check("stall_mode", bus.out_mode, held.m);
        check("stall_err", bus.out_adj_err, held.e);
      end
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (q.size() == 0) check("spurious_out", bus.out_valid, 0);
        else begin
          w = q.pop_front();
          check("out_data", bus.out_data, w.d);
          check("out_mode", bus.out_mode, w.m);
          check("out_adj_err", bus.out_adj_err, w.e);
          err_log.push_back(bus.out_adj_err);
        end
        if (stream_on) begin
          if (have_prev) check("stream_1bit", $countones(prev ^ bus.out_data), 1);
          prev = bus.out_data;
          have_prev = 1'b1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        q.push_back(model(bus.in_mode, bus.in_data));
      end
      hold = bus.out_valid && !bus.out_ready;
      held = '{bus.out_mode, bus.out_data, bus.out_adj_err};
    end
  end

  task automatic send(logic m, logic [W-1:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic lat(logic m, logic [W-1:0] d, logic [W-1:0] e);
    send(m, d);
    check("lat_early", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", bus.out_valid, 1);
    check("lat_data", bus.out_data, e);
    check("lat_mode", bus.out_mode, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, x0;
    logic took;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    hold = 1'b0;
    stream_on = 1'b0;
    have_prev = 1'b0;
    ref_valid = 1'b0;
    ref_word = '0;
    prev = '0;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_mode", bus.out_mode, 0);
    check("rst_out_adj_err", bus.out_adj_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat(1'b0, 5'b10110, 5'b11101);
    lat(1'b1, 5'b11101, 5'b10110);
    lat(1'b0, 5'b11111, 5'b10000);
    lat(1'b1, 5'b10000, 5'b11111);
    @(posedge clk);
    #1;
    stream_on = 1'b1;
    have_prev = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i <= 32; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = 1'b0;
      bus.in_data  = W'(i);
      @(negedge clk);
      check("stream_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_rate", xfer_cnt - x0, 33);
    stream_on = 1'b0;
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    send(1'b0, 5'd3);
    send(1'b0, 5'd9);
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'b1;
    bus.in_data  = 5'd21;
    repeat (3) @(posedge clk);
    #1;
    check("full_ready", bus.in_ready, 0);
    check("full_acc", acc_cnt - a0, 2);
    bus.out_ready = 1'b1;
    send(1'b1, 5'd21);
    send(1'b0, 5'd30);
    repeat (4) @(posedge clk);
    #1;
    check("stall_left", q.size(), 0);
    check("stall_acc", acc_cnt - a0, 4);
    bus.out_ready = 1'b0;
    send(1'b1, 5'd7);
    send(1'b0, 5'd12);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    ref_valid = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_mode", bus.out_mode, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", bus.out_valid, 0);
    err_log.delete();
    send(1'b1, 5'b00001);
    send(1'b1, 5'b00011);
    send(1'b1, 5'b00000);
    send(1'b1, 5'b00000);
    repeat (3) @(posedge clk);
    #1;
    check("adj_count", err_log.size(), 4);
    for (int i = 0; i < err_log.size() && i < 4; i++)
      check($sformatf("adj_err%0d", i), err_log[i], ADJ && (i >= 2));
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(3) != 0);
        bus.in_mode  = $urandom_range(1);
        bus.in_data  = W'($urandom);
      end
      bus.out_ready = ($urandom_range(2) != 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 0);
    check("rand_idle", bus.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
